// File: rtl/avr_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// avr_dmem_arbiter
//
// Shares the single-port AVR data memory between the CPU data port (port A)
// and a secondary master such as a debug loader or DMA engine (port B).
// Port A has priority. A saturating starvation counter forces port B through
// after STARVE_MAX consecutive denied cycles. The memory has a one-cycle
// synchronous read, so the arbiter records who issued the read accepted in the
// previous cycle and steers the returning data to that port only.
//
// Read owner states:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   OWN_NONE  | no read was accepted last cycle; nothing returns now
//   OWN_A     | port A read accepted last cycle; mem_rdata is A's data
//   OWN_B     | port B read accepted last cycle; mem_rdata is B's data
//
// Ports:
//   CLK, RST              system clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata   CPU request (level, held until granted)
//   a_gnt, stall          CPU grant (combinational) and CPU stall
//   a_rvalid, a_rdata     CPU read return, one cycle after the grant
//   b_req/b_we/b_addr/b_wdata   secondary master request
//   b_gnt                 secondary master grant (combinational)
//   b_rvalid, b_rdata     secondary master read return
//   mem_addr/mem_we/mem_wdata   memory command
//   mem_rdata             memory read data, valid the cycle after the address
// ---------------------------------------------------------------------------
module avr_dmem_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          stall,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    owner_t     rd_owner;
    owner_t     rd_owner_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       force_b;
    logic       mem_we_raw;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_owner   <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            rd_owner   <= rd_owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        force_b        = 1'b0;
        a_gnt          = 1'b0;
        b_gnt          = 1'b0;
        stall          = 1'b0;
        mem_addr       = a_addr;
        mem_wdata      = a_wdata;
        mem_we_raw     = 1'b0;
        mem_we         = 1'b0;
        starve_cnt_nxt = starve_cnt;
        rd_owner_nxt   = OWN_NONE;
        a_rvalid       = 1'b0;
        b_rvalid       = 1'b0;
        a_rdata        = '0;
        b_rdata        = '0;

        // Grant: A wins unless B has waited long enough to be forced through.
        force_b = b_req && (starve_cnt == STARVE_LIMIT);
        a_gnt   = a_req && !force_b;
        b_gnt   = b_req && !a_gnt;
        stall   = a_req && !a_gnt;

        // Memory command mux; an ungranted cycle never writes.
        if (b_gnt) begin
            mem_addr   = b_addr;
            mem_wdata  = b_wdata;
            mem_we_raw = b_we;
        end else begin
            mem_addr   = a_addr;
            mem_wdata  = a_wdata;
            mem_we_raw = a_we && a_gnt;
        end
        // Gate with reset so nothing is written while the system is held.
        mem_we = mem_we_raw && RST;

        // Starvation counter: counts consecutive denied B cycles, saturating.
        if (!b_req || b_gnt) begin
            starve_cnt_nxt = 4'd0;
        end else if (starve_cnt >= STARVE_LIMIT) begin
            starve_cnt_nxt = STARVE_LIMIT;
        end else begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end

        // Read owner for the data returning next cycle.
        if (a_gnt && !a_we) begin
            rd_owner_nxt = OWN_A;
        end else if (b_gnt && !b_we) begin
            rd_owner_nxt = OWN_B;
        end else begin
            rd_owner_nxt = OWN_NONE;
        end

        // Read return steering; the idle port sees zero.
        a_rvalid = (rd_owner == OWN_A);
        b_rvalid = (rd_owner == OWN_B);
        if (a_rvalid) begin
            a_rdata = mem_rdata;
        end
        if (b_rvalid) begin
            b_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avr_dmem_arbiter
//
// Cycle-by-cycle directed vectors for avr_dmem_arbiter. Each table row holds
// the inputs driven for one cycle and the outputs expected during that cycle
// (read returns refer to the previous row's grant). A behavioural write-first
// single-port memory with a one-cycle read sits on the memory port; it is
// preloaded with addr ^ 0x5A except for a few fixed locations.
// ---------------------------------------------------------------------------
module tb_avr_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic          a_req, a_we, a_gnt, stall, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem_model [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    avr_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .stall     (stall),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write-first synchronous memory.
    always @(posedge CLK) begin
        if (mem_we) begin
            mem_model[mem_addr] <= mem_wdata;
            mem_rdata           <= mem_wdata;
        end else begin
            mem_rdata <= mem_model[mem_addr];
        end
    end

    typedef struct {
        string      name;
        logic       rst;
        logic       a_req, a_we;
        logic [8:0] a_addr;
        logic [7:0] a_wdata;
        logic       b_req, b_we;
        logic [8:0] b_addr;
        logic [7:0] b_wdata;
        logic       e_a_gnt, e_b_gnt, e_stall, e_mem_we;
        logic       e_a_rv;
        logic [7:0] e_a_rd;
        logic       e_b_rv;
        logic [7:0] e_b_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r,
                                logic ar, logic aw, logic [8:0] aa, logic [7:0] ad,
                                logic br, logic bw, logic [8:0] ba, logic [7:0] bd,
                                logic ega, logic egb, logic est, logic ewe,
                                logic earv, logic [7:0] eard,
                                logic ebrv, logic [7:0] ebrd);
        vec_t v;
        v.name = n; v.rst = r;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
        v.e_a_gnt = ega; v.e_b_gnt = egb; v.e_stall = est; v.e_mem_we = ewe;
        v.e_a_rv = earv; v.e_a_rd = eard; v.e_b_rv = ebrv; v.e_b_rd = ebrd;
        return v;
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ar, input logic aw,
                         input logic [8:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw,
                         input logic [8:0] ba, input logic [7:0] bd);
        RST = r;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    initial begin
        bit isb, prevb, preva;
        string tag;

        for (int i = 0; i < (1 << AW); i++) mem_model[i] = 8'(i) ^ 8'h5A;
        mem_model[9'h020] = 8'h11;
        mem_model[9'h021] = 8'h22;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

        // Reset held with both requesting and A trying to write.
        vecs.push_back(mk("rst_hold",  0, 1,1,9'h010,8'hEE, 1,0,9'h011,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk("rst_hold2", 0, 1,1,9'h010,8'hEE, 1,0,9'h011,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk("rel_first", 1, 1,0,9'h010,8'h00, 1,0,9'h011,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00));
        // CPU write then read of the same address (previous read returns 0x4A).
        vecs.push_back(mk("a_wr",      1, 1,1,9'h010,8'hA5, 0,0,9'h000,8'h00, 1,0,0,1, 1,8'h4A, 0,8'h00));
        vecs.push_back(mk("a_rd",      1, 1,0,9'h010,8'h00, 0,0,9'h000,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk("a_rd_ret",  1, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00, 0,0,0,0, 1,8'hA5, 0,8'h00));
        // Contention: A reads 0x040 (0x1A), B reads 0x080 (0xDA).
        for (int k = 0; k < 10; k++) begin
            isb   = (k % 5 == 4);
            prevb = (k > 0) && ((k - 1) % 5 == 4);
            preva = (k > 0) && !prevb;
            tag   = $sformatf("cont%0d", k);
            vecs.push_back(mk(tag, 1, 1,0,9'h040,8'h00, 1,0,9'h080,8'h00,
                              !isb, isb, isb, 0,
                              preva, preva ? 8'h1A : 8'h00,
                              prevb, prevb ? 8'hDA : 8'h00));
        end
        vecs.push_back(mk("cont_ret",  1, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00, 0,0,0,0, 0,8'h00, 1,8'hDA));
        // Routing: A read then B read on adjacent cycles.
        vecs.push_back(mk("rt_a",      1, 1,0,9'h020,8'h00, 1,0,9'h021,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk("rt_b",      1, 0,0,9'h000,8'h00, 1,0,9'h021,8'h00, 0,1,0,0, 1,8'h11, 0,8'h00));
        vecs.push_back(mk("rt_ret",    1, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00, 0,0,0,0, 0,8'h00, 1,8'h22));
        // B write to the top address, then A reads it back.
        vecs.push_back(mk("b_wr",      1, 0,0,9'h000,8'h00, 1,1,9'h1FF,8'h3C, 0,1,0,1, 0,8'h00, 0,8'h00));
        vecs.push_back(mk("a_rd_top",  1, 1,0,9'h1FF,8'h00, 0,0,9'h000,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk("top_ret",   1, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00, 0,0,0,0, 1,8'h3C, 0,8'h00));
        // B alone: granted every cycle.
        for (int k = 0; k < 6; k++) begin
            tag = $sformatf("b_alone%0d", k);
            vecs.push_back(mk(tag, 1, 0,0,9'h000,8'h00, 1,0,9'h021,8'h00, 0,1,0,0,
                              0,8'h00, (k > 0), (k > 0) ? 8'h22 : 8'h00));
        end
        vecs.push_back(mk("b_alone_ret", 1, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00, 0,0,0,0, 0,8'h00, 1,8'h22));

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
                  vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
            #1;
            chk({vecs[i].name, ".a_gnt"},    {7'd0, a_gnt},    {7'd0, vecs[i].e_a_gnt});
            chk({vecs[i].name, ".b_gnt"},    {7'd0, b_gnt},    {7'd0, vecs[i].e_b_gnt});
            chk({vecs[i].name, ".stall"},    {7'd0, stall},    {7'd0, vecs[i].e_stall});
            chk({vecs[i].name, ".mem_we"},   {7'd0, mem_we},   {7'd0, vecs[i].e_mem_we});
            chk({vecs[i].name, ".a_rvalid"}, {7'd0, a_rvalid}, {7'd0, vecs[i].e_a_rv});
            chk({vecs[i].name, ".a_rdata"},  a_rdata,          vecs[i].e_a_rd);
            chk({vecs[i].name, ".b_rvalid"}, {7'd0, b_rvalid}, {7'd0, vecs[i].e_b_rv});
            chk({vecs[i].name, ".b_rdata"},  b_rdata,          vecs[i].e_b_rd);
        end

        // Reset during an A read grant, with B's starvation count at 3.
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            drive(1'b1, 1'b1, 1'b0, 9'h040, 8'h00, 1'b1, 1'b0, 9'h080, 8'h00);
        end
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 9'h010, 8'h00, 1'b1, 1'b0, 9'h080, 8'h00);
        #1;
        chk("midrst.a_gnt", {7'd0, a_gnt}, 8'd1);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        #1;
        chk("midrst.in_rst_a_rvalid", {7'd0, a_rvalid}, 8'd0);
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 9'h040, 8'h00, 1'b1, 1'b0, 9'h080, 8'h00);
        #1;
        chk("midrst.rel_a_rvalid", {7'd0, a_rvalid}, 8'd0);
        chk("midrst.rel_a_rdata",  a_rdata,          8'h00);
        // Cleared starvation count means four A grants before B is forced.
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                #1;
            end
            chk($sformatf("midrst.pat%0d.a_gnt", k), {7'd0, a_gnt}, (k == 4) ? 8'd0 : 8'd1);
            chk($sformatf("midrst.pat%0d.b_gnt", k), {7'd0, b_gnt}, (k == 4) ? 8'd1 : 8'd0);
        end

        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avr_dmem_arbiter.md
# avr_dmem_arbiter

Two-port arbiter that shares the single-port AVR data memory between the CPU data port (port A) and a secondary master such as a debug/loader or DMA engine (port B). The memory has a one-cycle synchronous read. The block grants at most one access per cycle, routes read data back to the requester that issued it, and raises a CPU stall while the CPU request is held off. Port A has priority; a starvation counter guarantees port B progress. It sits between `avr_cpu`'s data port and `data_memory`.

## Interface
- `AW`, default 9: data address width.
- `DW`, default 8: data width.
- `STARVE_MAX`, default 4: consecutive denied B cycles before B is forced through (range 1..15).

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  reset, asynchronous assert, active-low, synchronous release by the system.
- `a_req`  in  1  CPU access request, level, held until granted.
- `a_we`  in  1  CPU write (1) / read (0).
- `a_addr`  in  AW  CPU address.
- `a_wdata`  in  DW  CPU write data.
- `a_gnt`  out  1  CPU access accepted this cycle (combinational).
- `stall`  out  1  `a_req & ~a_gnt`; feeds the CPU and fetch stall input.
- `a_rvalid`  out  1  CPU read data valid on `a_rdata` (registered).
- `a_rdata`  out  DW  CPU read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: the same as the A-port signals, for port B.
- `mem_addr`  out  AW  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid the cycle after the address is presented.

## Operation
- Registered state:
  - `starve_cnt` (4 bits).
  - `rd_owner` (2 bits): NONE, A or B. Records who issued the read accepted in the previous cycle.
- Grant logic (combinational from the inputs and `starve_cnt`):
  - `force_b = b_req & (starve_cnt == STARVE_MAX)`.
  - `a_gnt = a_req & ~force_b`.
  - `b_gnt = b_req & ~a_gnt`.
  - `a_gnt` and `b_gnt` are never both 1.
- Memory mux:
  - When `b_gnt`: `mem_addr/mem_we/mem_wdata` come from port B.
  - Otherwise they come from port A, with `mem_we = a_we & a_gnt`.
  - `mem_we` is 0 in every cycle with no grant.
- `starve_cnt` update:
  - Cleared on `b_gnt` or `~b_req`.
  - Incremented when `b_req & ~b_gnt`.
  - Saturates at `STARVE_MAX`.
- `rd_owner` update:
  - Becomes A on `a_gnt & ~a_we`.
  - Becomes B on `b_gnt & ~b_we`.
  - Otherwise becomes NONE.
- Read return:
  - `a_rvalid = (rd_owner == A)`; `b_rvalid` likewise.
  - `x_rdata = mem_rdata` when `x_rvalid`, otherwise 0.
- Writes produce no rvalid. The write is committed at the edge that ends the grant cycle.
- Back-to-back accesses from the same port in consecutive cycles are legal, giving full throughput. Read-after-write to the same address in consecutive cycles returns the new data, because the memory is write-first at the edge.
- When both ports request every cycle, the sequence is A×`STARVE_MAX` then B×1, repeating.

## Timing
- Reset values (`RST` low, asynchronous):
  - `starve_cnt = 0`, `rd_owner = NONE`.
  - `a_rvalid = b_rvalid = 0`, `a_rdata = b_rdata = 0`.
  - Grants and `stall` follow the combinational equations.
  - `mem_we` is forced to 0 while `RST` is low.
- Grant latency: 0 cycles. Read data latency: 1 cycle after the grant cycle.
- Reset asserted mid-read: the pending `rvalid` is dropped and does not appear after reset release.
- `stall` is high in exactly the cycles where the CPU request is denied. The CPU must hold `a_addr/a_we/a_wdata` stable while stalled.
- A requester may drop `x_req` in the cycle after its grant. The arbiter keeps no per-request memory beyond `rd_owner`.
- B requesting alone: granted every cycle, and `starve_cnt` stays 0.

## Test plan
- Reset:
  - Stimulus: hold `RST` low with `a_req = b_req = 1`.
  - Required: `mem_we = 0`, `a_rvalid = b_rvalid = 0`, `starve_cnt = 0`.
  - After release: `a_gnt = 1` in the first cycle.
- CPU write then read:
  - Stimulus: A writes 0xA5 to 0x010, then reads 0x010 in the next cycle.
  - Required: `a_rvalid = 1` and `a_rdata = 0xA5` one cycle after the read grant; `stall = 0` throughout.
- Contention with `STARVE_MAX = 4`:
  - Stimulus: A and B both read continuously.
  - Required: grants go A,A,A,A,B repeating; `stall = 1` exactly in every 5th cycle; `b_rvalid` lands one cycle after each B grant with B's data.
- Routing check:
  - Stimulus: A reads 0x020 (0x11), and in the next cycle B is granted a read of 0x021 (0x22).
  - Required: `a_rvalid` pulses with 0x11, then `b_rvalid` pulses with 0x22; the two are never simultaneous.
- B write while A idle:
  - Stimulus: B writes 0x3C to 0x1FF (top address).
  - Required: `b_gnt = 1`, `mem_we = 1`, and a later A read of 0x1FF returns 0x3C.
- Reset mid-read:
  - Stimulus: assert `RST` in the same cycle as an A read grant.
  - Required: no `a_rvalid` is seen after release; `starve_cnt = 0`.
